// File: rtl/spi_fifo_bridge_pkg.sv
// Shared definitions for the SPI FIFO bridge: parameter defaults and the
// sequencer state encoding used by spi_fifo_bridge.
package spi_fifo_bridge_pkg;

    localparam int DEF_DATA_W  = 32;
    localparam int DEF_CLK_DIV = 4;
    localparam int DEF_CNT_W   = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_CS_SETUP,
        ST_SHIFT,
        ST_CS_HOLD,
        ST_PUSH,
        ST_GAP
    } state_t;

endpackage

// File: rtl/spi_fifo_bridge_if.sv
// Bus bundle between the bridge and its surroundings: FIFO A read side,
// FIFO B write side and the SPI pins.
//   master : the bridge (reads FIFO A, writes FIFO B, drives SPI pins)
//   slave  : the FIFOs / chip side
interface spi_fifo_bridge_if
    import spi_fifo_bridge_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
);
    logic [DATA_W-1:0] fifoa_dout;
    logic              fifoa_empty;
    logic              fifoa_rd_en;
    logic [DATA_W-1:0] fifob_din;
    logic              fifob_wr_en;
    logic              fifob_full;
    logic              spi_sck;
    logic              spi_mosi;
    logic              spi_miso;
    logic              spi_cs;

    modport master (
        input  fifoa_dout, fifoa_empty, fifob_full, spi_miso,
        output fifoa_rd_en, fifob_din, fifob_wr_en, spi_sck, spi_mosi, spi_cs
    );

    modport slave (
        output fifoa_dout, fifoa_empty, fifob_full, spi_miso,
        input  fifoa_rd_en, fifob_din, fifob_wr_en, spi_sck, spi_mosi, spi_cs
    );
endinterface

// File: rtl/spi_fifo_bridge_shift_core.sv
// spi_shift_core: SPI mode-0 shifter (MSB first) with SCK divider.
//   clk, rst   : clock, synchronous active-high reset
//   load       : latch load_data into the transmit register, restart divider
//   load_data  : word to transmit
//   go         : run the divider / shifting while high
//   miso       : serial input, sampled on SCK rising edges
//   sck, mosi  : serial clock (idles low) and data out (tx MSB)
//   rx_data    : received word
//   word_done  : high on the cycle that produces the DATA_W-th falling edge
module spi_shift_core
    import spi_fifo_bridge_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              go,
    input  logic              miso,
    output logic              sck,
    output logic              mosi,
    output logic [DATA_W-1:0] rx_data,
    output logic              word_done
);
    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int BIT_W = $clog2(DATA_W);

    logic [DIV_W-1:0]  div_cnt;
    logic [BIT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] tx_shift;
    logic [DATA_W-1:0] rx_shift;
    logic              sck_q;
    logic              tick;

    // tick marks the last cycle of an SCK half period
    assign tick      = go && (div_cnt == DIV_W'(CLK_DIV - 1));
    assign word_done = tick && sck_q && (bit_cnt == BIT_W'(DATA_W - 1));

    assign sck     = sck_q;
    assign mosi    = tx_shift[DATA_W-1];
    assign rx_data = rx_shift;

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt  <= '0;
            bit_cnt  <= '0;
            tx_shift <= '0;
            rx_shift <= '0;
            sck_q    <= 1'b0;
        end else if (load) begin
            tx_shift <= load_data;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            sck_q    <= 1'b0;
        end else if (go) begin
            if (tick) begin
                div_cnt <= '0;
                sck_q   <= ~sck_q;
                if (!sck_q) begin
                    rx_shift <= {rx_shift[DATA_W-2:0], miso};
                end else begin
                    tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
                    bit_cnt  <= bit_cnt + BIT_W'(1);
                end
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
        end
    end
endmodule

// File: rtl/spi_fifo_bridge.sv
// spi_fifo_bridge: drains FIFO A word by word over SPI and pushes each word
// received on MISO into FIFO B.
//   clk, rst  : okClk, synchronous active-high reset
//   start     : one-cycle batch trigger (ignored while busy)
//   bus       : FIFO A/B handshakes and SPI pins (master side)
//   busy      : state is not IDLE
//   done      : one-cycle pulse at the end of a batch
//   word_cnt  : words completed since the last start, saturating
module spi_fifo_bridge
    import spi_fifo_bridge_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int CLK_DIV = DEF_CLK_DIV,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    spi_fifo_bridge_if.master   bus,
    output logic                busy,
    output logic                done,
    output logic [CNT_W-1:0]    word_cnt
);
    localparam int TMR_W = $clog2(CLK_DIV);

    state_t           state, state_nx;
    logic [TMR_W-1:0] tmr;
    logic             tmr_last;
    logic             timed;
    logic             done_nx;
    logic             clr_cnt;
    logic             word_done;
    logic             push;

    assign tmr_last = (tmr == TMR_W'(CLK_DIV - 1));
    assign timed    = (state == ST_CS_SETUP) || (state == ST_CS_HOLD) || (state == ST_GAP);
    assign push     = (state == ST_PUSH) && !bus.fifob_full;

    assign bus.fifoa_rd_en = (state == ST_FETCH) && !bus.fifoa_empty;
    assign bus.fifob_wr_en = push;
    assign bus.spi_cs      = !((state == ST_CS_SETUP) || (state == ST_SHIFT) || (state == ST_CS_HOLD));
    assign busy            = (state != ST_IDLE);

    spi_shift_core #(
        .DATA_W  (DATA_W),
        .CLK_DIV (CLK_DIV)
    ) u_core (
        .clk       (clk),
        .rst       (rst),
        .load      (state == ST_LOAD),
        .load_data (bus.fifoa_dout),
        .go        (state == ST_SHIFT),
        .miso      (bus.spi_miso),
        .sck       (bus.spi_sck),
        .mosi      (bus.spi_mosi),
        .rx_data   (bus.fifob_din),
        .word_done (word_done)
    );

    always_comb begin
        state_nx = state;
        done_nx  = 1'b0;
        clr_cnt  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    clr_cnt = 1'b1;
                    if (!bus.fifoa_empty) state_nx = ST_FETCH;
                    else                  done_nx  = 1'b1;
                end
            end
            ST_FETCH:    state_nx = ST_LOAD;
            ST_LOAD:     state_nx = ST_CS_SETUP;
            ST_CS_SETUP: if (tmr_last) state_nx = ST_SHIFT;
            ST_SHIFT:    if (word_done) state_nx = ST_CS_HOLD;
            ST_CS_HOLD:  if (tmr_last) state_nx = ST_PUSH;
            ST_PUSH:     if (!bus.fifob_full) state_nx = ST_GAP;
            ST_GAP: begin
                // Words arriving in FIFO A during the batch are picked up here.
                if (tmr_last) begin
                    if (!bus.fifoa_empty) begin
                        state_nx = ST_FETCH;
                    end else begin
                        state_nx = ST_IDLE;
                        done_nx  = 1'b1;
                    end
                end
            end
            default:     state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            tmr      <= '0;
            done     <= 1'b0;
            word_cnt <= '0;
        end else begin
            state <= state_nx;
            done  <= done_nx;
            if (state_nx != state) tmr <= '0;
            else if (timed)        tmr <= tmr + TMR_W'(1);
            if (clr_cnt)                     word_cnt <= '0;
            else if (push && word_cnt != '1) word_cnt <= word_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_spi_fifo_bridge.sv
module tb_spi_fifo_bridge;
    localparam int DW = 32;
    localparam int CD = 4;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          busy;
    logic          done;
    logic [CW-1:0] word_cnt;

    spi_fifo_bridge_if #(.DATA_W(DW)) bus();

    spi_fifo_bridge #(.DATA_W(DW), .CLK_DIV(CD), .CNT_W(CW)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .bus      (bus.master),
        .busy     (busy),
        .done     (done),
        .word_cnt (word_cnt)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // FIFO A model: registered read data, one cycle after rd_en
    logic [DW-1:0] fa_mem [16];
    int unsigned   fa_wr = 0;
    int unsigned   fa_rd = 0;
    int            rd_viol = 0;
    assign bus.fifoa_empty = (fa_wr == fa_rd);
    always @(posedge clk) begin
        if (bus.fifoa_rd_en) begin
            if (fa_wr == fa_rd) rd_viol <= rd_viol + 1;
            else begin
                bus.fifoa_dout <= fa_mem[fa_rd[3:0]];
                fa_rd <= fa_rd + 1;
            end
        end
    end

    // FIFO B model
    logic [DW-1:0] fb_mem [16];
    int unsigned   fb_wr = 0;
    logic          fb_full = 1'b0;
    int            wr_viol = 0;
    assign bus.fifob_full = fb_full;
    always @(posedge clk) begin
        if (bus.fifob_wr_en) begin
            if (fb_full) wr_viol <= wr_viol + 1;
            else begin
                fb_mem[fb_wr[3:0]] <= bus.fifob_din;
                fb_wr <= fb_wr + 1;
            end
        end
    end

    // MISO source: loopback or fixed level
    logic loop_en = 1'b1;
    logic miso_fix = 1'b0;
    assign bus.spi_miso = loop_en ? bus.spi_mosi : miso_fix;

    // Pin monitors
    logic          sck_q = 1'b0;
    logic          cs_q = 1'b1;
    int            sck_rises = 0;
    int            done_cnt = 0;
    int            cs_falls = 0;
    int            hi_run = 0;
    int            last_gap = 0;
    logic [DW-1:0] mosi_cap = '0;
    always @(posedge clk) begin
        sck_q <= bus.spi_sck;
        cs_q  <= bus.spi_cs;
        if (bus.spi_sck && !sck_q) begin
            sck_rises <= sck_rises + 1;
            mosi_cap  <= {mosi_cap[DW-2:0], bus.spi_mosi};
        end
        if (done) done_cnt <= done_cnt + 1;
        if (bus.spi_cs) hi_run <= hi_run + 1;
        else            hi_run <= 0;
        if (!bus.spi_cs && cs_q) begin
            cs_falls <= cs_falls + 1;
            last_gap <= hi_run;
        end
    end

    task automatic push_a(input logic [DW-1:0] w);
        fa_mem[fa_wr[3:0]] = w;
        fa_wr = fa_wr + 1;
    endtask

    // Pulse start, then count cycles until done is seen (-1 on timeout).
    // A second start pulse is issued at cycle extra_at (0 = none).
    task automatic run_start(input int budget, input int extra_at, output int lat);
        lat = -1;
        @(negedge clk);
        start = 1'b1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            start = (i == extra_at);
            if (done) begin
                lat = i;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        compared++;
        if ({bus.spi_cs, bus.spi_sck, bus.spi_mosi, bus.fifoa_rd_en, bus.fifob_wr_en, busy, done} !== 7'b1000000) begin
            mismatched++;
            $display("FAIL reset_ctl: got %b expected 1000000",
                     {bus.spi_cs, bus.spi_sck, bus.spi_mosi, bus.fifoa_rd_en, bus.fifob_wr_en, busy, done});
        end
        compared++;
        if (bus.fifob_din !== 32'h0) begin
            mismatched++; $display("FAIL reset_din: got %h expected 0", bus.fifob_din);
        end
        compared++;
        if (word_cnt !== 16'd0) begin
            mismatched++; $display("FAIL reset_word_cnt: got %0d expected 0", word_cnt);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_word();
        int lat; int r0; int d0; int unsigned b0; int low;
        loop_en = 1'b1;
        push_a(32'hA5A5_0F0F);
        r0 = sck_rises; d0 = done_cnt; b0 = fb_wr;
        run_start(2000, 0, lat);
        compared++;
        if (lat !== 272) begin mismatched++; $display("FAIL single_latency: got %0d expected 272", lat); end
        compared++;
        if (sck_rises - r0 !== 32) begin mismatched++; $display("FAIL single_sck_rises: got %0d expected 32", sck_rises - r0); end
        compared++;
        if (mosi_cap !== 32'hA5A5_0F0F) begin mismatched++; $display("FAIL single_mosi: got %h expected a5a50f0f", mosi_cap); end
        compared++;
        if (fb_wr - b0 !== 1) begin mismatched++; $display("FAIL single_fb_writes: got %0d expected 1", fb_wr - b0); end
        compared++;
        if (fb_mem[b0[3:0]] !== 32'hA5A5_0F0F) begin mismatched++; $display("FAIL single_fb_data: got %h expected a5a50f0f", fb_mem[b0[3:0]]); end
        compared++;
        if (word_cnt !== 16'd1) begin mismatched++; $display("FAIL single_word_cnt: got %0d expected 1", word_cnt); end
        low = 0;
        for (int i = 0; i < CD; i++) begin
            @(negedge clk);
            if (!bus.spi_cs) low++;
        end
        compared++;
        if (done_cnt - d0 !== 1) begin mismatched++; $display("FAIL single_done_pulses: got %0d expected 1", done_cnt - d0); end
        compared++;
        if (low !== 0) begin mismatched++; $display("FAIL single_cs_after: got %0d low cycles expected 0", low); end
    endtask

    task automatic test_fixed_miso();
        int lat; int unsigned b0;
        loop_en = 1'b0; miso_fix = 1'b1;
        push_a(32'h0000_0000);
        b0 = fb_wr;
        run_start(2000, 0, lat);
        compared++;
        if (fb_mem[b0[3:0]] !== 32'hFFFF_FFFF || fb_wr - b0 !== 1) begin
            mismatched++; $display("FAIL fixed_miso_data: got %h (%0d writes) expected ffffffff", fb_mem[b0[3:0]], fb_wr - b0);
        end
        compared++;
        if (mosi_cap !== 32'h0) begin mismatched++; $display("FAIL fixed_miso_mosi: got %h expected 0", mosi_cap); end
        loop_en = 1'b1; miso_fix = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_batch();
        int lat; int d0; int c0; int unsigned b0;
        push_a(32'h1); push_a(32'h2); push_a(32'h3);
        d0 = done_cnt; c0 = cs_falls; b0 = fb_wr;
        run_start(3000, 100, lat);
        @(negedge clk);
        compared++;
        if (lat !== 814) begin mismatched++; $display("FAIL batch_latency: got %0d expected 814", lat); end
        compared++;
        if (fb_wr - b0 !== 3) begin mismatched++; $display("FAIL batch_fb_writes: got %0d expected 3", fb_wr - b0); end
        for (int unsigned k = 0; k < 3; k++) begin
            int unsigned idx;
            idx = b0 + k;
            compared++;
            if (fb_mem[idx[3:0]] !== 32'(k + 1)) begin
                mismatched++; $display("FAIL batch_fb_word%0d: got %h expected %h", k, fb_mem[idx[3:0]], 32'(k + 1));
            end
        end
        compared++;
        if (word_cnt !== 16'd3) begin mismatched++; $display("FAIL batch_word_cnt: got %0d expected 3", word_cnt); end
        compared++;
        if (done_cnt - d0 !== 1) begin mismatched++; $display("FAIL batch_done_pulses: got %0d expected 1", done_cnt - d0); end
        compared++;
        if (cs_falls - c0 !== 3) begin mismatched++; $display("FAIL batch_cs_frames: got %0d expected 3", cs_falls - c0); end
        compared++;
        if (last_gap !== 7) begin mismatched++; $display("FAIL batch_cs_gap: got %0d expected 7", last_gap); end
    endtask

    task automatic test_empty_start();
        int lat; int d0; int r0; int c0;
        d0 = done_cnt; r0 = sck_rises; c0 = cs_falls;
        run_start(20, 0, lat);
        repeat (10) @(negedge clk);
        compared++;
        if (lat !== 1) begin mismatched++; $display("FAIL empty_latency: got %0d expected 1", lat); end
        compared++;
        if (sck_rises - r0 !== 0 || cs_falls - c0 !== 0) begin
            mismatched++; $display("FAIL empty_no_spi: got %0d sck rises %0d cs falls expected 0 0", sck_rises - r0, cs_falls - c0);
        end
        compared++;
        if (word_cnt !== 16'd0) begin mismatched++; $display("FAIL empty_word_cnt: got %0d expected 0", word_cnt); end
        compared++;
        if (done_cnt - d0 !== 1) begin mismatched++; $display("FAIL empty_done_pulses: got %0d expected 1", done_cnt - d0); end
    endtask

    task automatic test_backpressure();
        int unsigned b0; int bad; bit seen_lo; bit seen_hi;
        push_a(32'h5A5A_C3C3);
        b0 = fb_wr;
        fb_full = 1'b1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        seen_lo = 0; seen_hi = 0;
        for (int i = 0; i < 100; i++) begin
            if (!bus.spi_cs) begin seen_lo = 1; break; end
            @(negedge clk);
        end
        for (int i = 0; i < 700; i++) begin
            if (bus.spi_cs) begin seen_hi = 1; break; end
            @(negedge clk);
        end
        compared++;
        if (!(seen_lo && seen_hi)) begin mismatched++; $display("FAIL bp_reach_push: got %b%b expected 11", seen_lo, seen_hi); end
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            if (bus.fifob_wr_en || !bus.spi_cs || bus.spi_sck) bad++;
            @(negedge clk);
        end
        compared++;
        if (bad !== 0) begin mismatched++; $display("FAIL bp_stall_pins: got %0d bad cycles expected 0", bad); end
        compared++;
        if (fb_wr - b0 !== 0) begin mismatched++; $display("FAIL bp_no_write: got %0d writes expected 0", fb_wr - b0); end
        fb_full = 1'b0;
        #1;
        compared++;
        if (bus.fifob_wr_en !== 1'b1) begin mismatched++; $display("FAIL bp_push_on_release: got %b expected 1", bus.fifob_wr_en); end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) break;
        end
        compared++;
        if (fb_wr - b0 !== 1 || fb_mem[b0[3:0]] !== 32'h5A5A_C3C3) begin
            mismatched++; $display("FAIL bp_data: got %h (%0d writes) expected 5a5ac3c3", fb_mem[b0[3:0]], fb_wr - b0);
        end
        compared++;
        if (word_cnt !== 16'd1) begin mismatched++; $display("FAIL bp_word_cnt: got %0d expected 1", word_cnt); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_shift();
        int lat; int r0; int unsigned b0;
        push_a(32'h1357_9BDF);
        r0 = sck_rises; b0 = fb_wr;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (sck_rises - r0 >= 11) break;
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        compared++;
        if ({bus.spi_cs, bus.spi_sck, busy} !== 3'b100) begin
            mismatched++; $display("FAIL rst_mid_pins: got cs/sck/busy %b expected 100", {bus.spi_cs, bus.spi_sck, busy});
        end
        compared++;
        if (word_cnt !== 16'd0) begin mismatched++; $display("FAIL rst_mid_word_cnt: got %0d expected 0", word_cnt); end
        rst = 1'b0;
        repeat (5) @(negedge clk);
        compared++;
        if (fb_wr - b0 !== 0) begin mismatched++; $display("FAIL rst_mid_no_write: got %0d writes expected 0", fb_wr - b0); end
        push_a(32'h2468_ACE0);
        run_start(2000, 0, lat);
        compared++;
        if (lat !== 272) begin mismatched++; $display("FAIL rst_fresh_latency: got %0d expected 272", lat); end
        compared++;
        if (fb_wr - b0 !== 1 || fb_mem[b0[3:0]] !== 32'h2468_ACE0) begin
            mismatched++; $display("FAIL rst_fresh_data: got %h (%0d writes) expected 2468ace0", fb_mem[b0[3:0]], fb_wr - b0);
        end
        compared++;
        if (word_cnt !== 16'd1) begin mismatched++; $display("FAIL rst_fresh_word_cnt: got %0d expected 1", word_cnt); end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_fixed_miso();
        test_batch();
        test_empty_start();
        test_backpressure();
        test_reset_mid_shift();
        repeat (3) @(negedge clk);
        compared++;
        if (rd_viol !== 0) begin mismatched++; $display("FAIL rd_on_empty: got %0d expected 0", rd_viol); end
        compared++;
        if (wr_viol !== 0) begin mismatched++; $display("FAIL wr_on_full: got %0d expected 0", wr_viol); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
